z80_bus_arbiter: RTL
====================

Name: z80_bus_arbiter

Overview:
- Shares one single-port synchronous ROM/RAM between the Z80 memory bus and the SPI diagnostic/loader requester.
- Z80 strobes are synchronised into the FPGA clock. Z80 accesses have priority. WAIT is stretched while the memory is busy.
- Sits between the Z80 pin wrapper and the memory array, in place of direct enable/data-out gating.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
SYNC_STAGES, 2, flip-flop stages on mreq_n/rd_n/wr_n (min 2)
WAIT_MAX, 15, max consecutive clk cycles wait_n may be held low before forced release

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mreq_n  in  1  Z80 MREQ, raw, asynchronous
rd_n  in  1  Z80 RD, raw
wr_n  in  1  Z80 WR, raw
address  in  ADDR_W  Z80 address bus
z_wdata  in  DATA_W  Z80 data bus input
z_rdata  out  DATA_W  data driven to Z80 on reads
data_oe  out  1  enable for the Z80 data-bus output buffer
wait_n  out  1  Z80 WAIT, active low
diag_req  in  1  diagnostic request; held until diag_done
diag_we  in  1  1 = write, 0 = read
diag_addr  in  ADDR_W  diagnostic address
diag_wdata  in  DATA_W  diagnostic write data
diag_rdata  out  DATA_W  diagnostic read data
diag_done  out  1  one-cycle completion pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

Behaviour:
Reset values:
- All outputs 0 except wait_n=1.
- Sync registers reset to 1 (strobes inactive).
- State = IDLE.

Synchronisation:
- s_mreq, s_rd and s_wr are the SYNC_STAGES-delayed versions of the raw strobes.
- Address and z_wdata are sampled only on state-entry cycles. They are stable at that point by Z80 timing.

States:
- IDLE:
  - If s_mreq=0 and s_rd=0, go to Z_RD.
  - Else if s_mreq=0 and s_wr=0, go to Z_WR.
  - Else if diag_req=1, go to D_ACC.
  - Z80 wins when it is simultaneous with diag_req.
- Z_RD:
  - mem_en=1, mem_we=0, mem_addr=address, for 1 cycle.
  - Then go to Z_CAP.
- Z_CAP:
  - z_rdata <= mem_rdata.
  - Next cycle: data_oe=1, go to Z_HOLD.
- Z_WR:
  - mem_en=1, mem_we=1, mem_addr=address, mem_wdata=z_wdata, for 1 cycle.
  - Then go to Z_HOLD.
- Z_HOLD:
  - Stay until s_mreq=1. Then data_oe=0 and go to IDLE.
  - If s_rd rises first, data_oe drops that cycle.
- D_ACC:
  - mem_en=1, mem_we=diag_we, address and data taken from diag_*, for 1 cycle.
  - Then go to D_DONE.
- D_DONE:
  - diag_rdata <= mem_rdata (reads only).
  - diag_done=1 for 1 cycle, go to IDLE.
  - A diag request still asserted in IDLE afterwards starts a new access. The requester must drop diag_req on diag_done.

Wait generation:
- wait_n=0 when raw mreq_n=0 and raw rd_n=0 and the state is not Z_HOLD.
- This is combinational on the raw pins, so it covers sync latency.
- wait_n=0 also when raw mreq_n=0 and the state is D_ACC or D_DONE.
- Z80 writes never wait unless a diag access is in flight.
- Watchdog counter:
  - Counts cycles with wait_n=0 and clears when wait_n=1.
  - At WAIT_MAX it forces wait_n=1 until raw mreq_n returns high.
  - If forced, the read returns the last z_rdata.

Boundaries:
- Worst-case Z80 wait = SYNC_STAGES + 3 cycles: a diag access in progress, plus read, plus capture.
- mreq_n rising during Z_RD or Z_CAP: finish the memory cycle, go to IDLE, data_oe stays 0.
- Reset mid-operation: immediate return to reset values. diag_done is not pulsed; the requester must reissue.
- A refresh cycle (mreq_n low, rd_n and wr_n high) is ignored and stays in IDLE.

Test Plan:
- Z80 read: preload mem[0x1234]=0xA5; mreq_n and rd_n low with address 0x1234. Required: wait_n low until data_oe=1 and z_rdata=0xA5. data_oe drops within SYNC_STAGES+1 cycles of rd_n high.
- Z80 write: mreq_n and wr_n low, address 0x8000, z_wdata 0x3C. Required: single mem_en+mem_we pulse with addr 0x8000 and data 0x3C; wait_n stays 1.
- Diag read then write: diag read of 0x0010 (preset 0x77) gives diag_done pulse with diag_rdata=0x77. Diag write 0x0011 := 0x99 is then read back as 0x99.
- Collision: diag_req raised in the same cycle s_mreq and s_rd go low. Required: the Z80 read is served first; diag_done follows 2 cycles after return to IDLE; both data values are correct.
- Diag in flight, then Z80 read: required wait_n low for ≤ SYNC_STAGES+3 cycles. Watchdog: hold the FSM in D_ACC via a forced stall in the bench; wait_n must return to 1 after WAIT_MAX cycles.
- Reset asserted in Z_CAP with data_oe pending: required all outputs at reset values immediately and no diag_done. After rst_n deasserts, a normal read succeeds.

Source files
------------

// File: rtl/z80_bus_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port synchronous memory between the Z80 bus and the SPI
// diagnostic requester; Z80 has priority and WAIT covers sync + arbitration.
module z80_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_MAX    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mreq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] z_wdata,
    output logic [DATA_W-1:0] z_rdata,
    output logic              data_oe,
    output logic              wait_n,
    input  logic              diag_req,
    input  logic              diag_we,
    input  logic [ADDR_W-1:0] diag_addr,
    input  logic [DATA_W-1:0] diag_wdata,
    output logic [DATA_W-1:0] diag_rdata,
    output logic              diag_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, Z_RD, Z_CAP, Z_WR, Z_HOLD, D_ACC, D_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] mreq_sq, rd_sq, wr_sq;
    logic                   s_mreq, s_rd, s_wr;
    logic                   z_rd_req, z_wr_req;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] z_rdata_q;
    logic [DATA_W-1:0] diag_rdata_q;
    logic              oe_q;
    logic              dwe_q;

    logic             wait_raw, wait_act;
    logic [CNT_W-1:0] cnt_q;
    logic             forced_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreq_sq <= '1;
            rd_sq   <= '1;
            wr_sq   <= '1;
        end else begin
            mreq_sq <= {mreq_sq[SYNC_STAGES-2:0], mreq_n};
            rd_sq   <= {rd_sq[SYNC_STAGES-2:0], rd_n};
            wr_sq   <= {wr_sq[SYNC_STAGES-2:0], wr_n};
        end
    end

    assign s_mreq   = mreq_sq[SYNC_STAGES-1];
    assign s_rd     = rd_sq[SYNC_STAGES-1];
    assign s_wr     = wr_sq[SYNC_STAGES-1];
    assign z_rd_req = !s_mreq && !s_rd;
    assign z_wr_req = !s_mreq && !s_wr;

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        diag_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (z_rd_req)      state_d = Z_RD;
                else if (z_wr_req) state_d = Z_WR;
                else if (diag_req) state_d = D_ACC;
            end
            Z_RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
                state_d  = Z_CAP;
            end
            Z_CAP: state_d = s_mreq ? IDLE : Z_HOLD;
            Z_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_d   = Z_HOLD;
            end
            Z_HOLD: if (s_mreq) state_d = IDLE;
            D_ACC: begin
                mem_en    = 1'b1;
                mem_we    = diag_we;
                mem_addr  = diag_addr;
                mem_wdata = diag_wdata;
                state_d   = D_DONE;
            end
            D_DONE: begin
                diag_done = 1'b1;
                // a Z80 cycle that synced during the diag access skips IDLE
                if (z_rd_req)      state_d = Z_RD;
                else if (z_wr_req) state_d = Z_WR;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            z_rdata_q    <= '0;
            diag_rdata_q <= '0;
            oe_q         <= 1'b0;
            dwe_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == Z_RD || state_d == Z_WR) begin
                addr_q  <= address;
                wdata_q <= z_wdata;
            end
            if (state_d == D_ACC) dwe_q <= diag_we;
            if (state_q == Z_CAP) z_rdata_q <= mem_rdata;
            if (state_q == D_DONE && !dwe_q) diag_rdata_q <= mem_rdata;
            oe_q <= (state_q == Z_CAP && state_d == Z_HOLD) ||
                    (state_q == Z_HOLD && oe_q && !s_rd && !s_mreq);
        end
    end

    assign z_rdata    = z_rdata_q;
    assign data_oe    = oe_q && !s_rd && !s_mreq;
    assign diag_rdata = (state_q == D_DONE && !dwe_q) ? mem_rdata
                                                      : diag_rdata_q;

    // raw pins, so WAIT asserts before the strobes are synchronised
    assign wait_raw = !mreq_n &&
                      ((!rd_n && state_q != Z_HOLD) ||
                       state_q == D_ACC || state_q == D_DONE);
    assign wait_act = rst_n && wait_raw && !forced_q;
    assign wait_n   = !wait_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            forced_q <= 1'b0;
        end else if (mreq_n) begin
            cnt_q    <= '0;
            forced_q <= 1'b0;
        end else if (wait_act) begin
            if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                cnt_q    <= '0;
                forced_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule
